// File: rtl/fetch_controller_if.sv
// Decode-side handshake of the fetch controller: head-of-queue instruction plus valid/ready.
interface fetch_controller_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction memory and
// buffers fetched words in a small queue drained by decode.
module fetch_controller #(
    parameter int unsigned MEM_SIZE   = 256,
    parameter int unsigned DEPTH      = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [31:0]         imem_addr,
    input  logic [31:0]         imem_data,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    fetch_controller_if.master  dec,
    output logic                halted,
    output logic [31:0]         fetch_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic [31:0]       q_pc_q    [DEPTH];
    logic [31:0]       q_instr_q [DEPTH];

    logic head_valid;
    logic pop;
    logic push;
    logic redir_act;
    logic pc_oob;

    assign head_valid = (count_q != '0);
    assign pop        = head_valid && dec.out_ready;
    assign redir_act  = redirect_valid && (state_q != StIdle);
    assign pc_oob     = {2'b00, fetch_pc_q[31:2]} >= MEM_SIZE;
    // A full queue may still accept a word when the head retires in the same cycle.
    assign push       = (state_q == StRun) && !redirect_valid && !pc_oob &&
                        ((count_q != Full) || pop);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[wr_ptr_q]    <= fetch_pc_q;
            q_instr_q[wr_ptr_q] <= imem_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (redirect_valid) begin
                    state_d = StRun;
                end else if (pc_oob) begin
                    state_d = StHalted;
                end else if (push && (imem_data == HALT_INSTR)) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (redirect_valid) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fetch_count_d = fetch_count_q;
        if (redir_act) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (push) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                wr_ptr_d      = wr_ptr_q + PtrW'(1);
                fetch_count_d = fetch_count_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Outputs
    always_comb begin
        halted        = (state_q == StHalted);
        imem_addr     = {2'b00, fetch_pc_q[31:2]};
        fetch_count   = fetch_count_q;
        dec.out_valid = head_valid;
        dec.out_instr = head_valid ? q_instr_q[rd_ptr_q] : 32'h0;
        dec.out_pc    = head_valid ? q_pc_q[rd_ptr_q] : 32'h0;
    end

endmodule
